mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width of both requesters and the memory port.
REQ-002 SHALL have parameter DATA_W, default 32: data width; strobe width is DATA_W/8.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port if_req_i, input, 1: fetch read request.
REQ-006 SHALL have port if_addr_i, input, ADDR_W: fetch address.
REQ-007 SHALL have port if_gnt_o, output, 1: fetch request accepted this cycle.
REQ-008 SHALL have ports if_rvalid_o (output, 1) and if_rdata_o (output, DATA_W): fetch read response.
REQ-009 SHALL have port ls_req_i, input, 1: load/store request.
REQ-010 SHALL have ports ls_addr_i (input, ADDR_W), ls_we_i (input, 1), ls_wdata_i (input, DATA_W) and ls_strb_i (input, DATA_W/8): load/store address, write enable, write data and byte strobes.
REQ-011 SHALL have port ls_gnt_o, output, 1: load/store request accepted this cycle.
REQ-012 SHALL have ports ls_rvalid_o (output, 1) and ls_rdata_o (output, DATA_W): load read response.
REQ-013 SHALL have ports mem_addr_o (output, ADDR_W), mem_wdata_o (output, DATA_W), mem_strb_o (output, DATA_W/8) and mem_we_o (output, 1): shared memory request.
REQ-014 SHALL have port mem_rdata_i, input, DATA_W: shared memory read data, valid one cycle after the request.

Function
REQ-015 SHALL grant at most one requester per cycle; the grant is combinational, in the same cycle as the request.
REQ-016 With only one requester active, SHALL grant it unconditionally.
REQ-017 SHALL drive mem_addr_o from the granted requester's address, or 0 when nothing is granted.
REQ-018 SHALL drive mem_we_o = ls_gnt_o & ls_we_i; a fetch grant never writes.
REQ-019 SHALL drive mem_wdata_o/mem_strb_o from ls_* when ls_gnt_o=1, else 0.
REQ-020 SHALL register the owner of each granted read (state IDLE, RD_IF or RD_LS), updated every cycle.
- No grant, or a granted write -> IDLE.
- Granted fetch -> RD_IF.
- Granted load -> RD_LS.
REQ-021 In state RD_IF, SHALL assert if_rvalid_o=1 with if_rdata_o=mem_rdata_i; otherwise if_rvalid_o=0 and if_rdata_o=0.
REQ-022 In state RD_LS, SHALL assert ls_rvalid_o=1 with ls_rdata_o=mem_rdata_i; otherwise ls_rvalid_o=0 and ls_rdata_o=0.
REQ-023 Read latency SHALL be exactly 1 cycle from grant to rvalid.
REQ-024 Back-to-back grants SHALL be allowed every cycle, with a new grant overlapping the previous response.
REQ-025 Writes SHALL produce no rvalid.
REQ-026 A requester not granted SHALL hold its request, with stable address and data, until granted; the arbiter does not buffer requests.
REQ-027 Request inputs SHALL be sampled only while reset=0.

Reset
REQ-028 On reset assertion, asynchronously:
- owner state -> IDLE;
- rvalid outputs and rdata outputs -> 0;
- round-robin pointer (when compiled in) -> favour fetch.
REQ-029 While reset=1, SHALL force if_gnt_o=0, ls_gnt_o=0, mem_we_o=0 and mem_addr_o=0.
REQ-030 A reset between grant and response SHALL discard the response; no rvalid is asserted after reset release.

Configuration
REQ-031 Macro MEM_ARBITER_RR_EN SHALL select the contention policy.
REQ-032 MEM_ARBITER_RR_EN undefined: fixed priority; on contention ls wins and if stalls.
REQ-033 MEM_ARBITER_RR_EN defined: a 1-bit priority pointer selects the winner on contention.
- After each contended grant, the pointer flips to favour the loser.
- Uncontended grants leave the pointer unchanged.
- Reset value favours fetch.

Verification
REQ-034 Fetch only: if_req=1, if_addr=0x10, mem_rdata=0xDEADBEEF next cycle -> if_gnt=1 in cycle 0; if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 1; ls_rvalid=0.
REQ-035 Store: ls_req=1, we=1, addr=0x20, wdata=0x12345678, strb=0xF -> mem_we=1 with matching addr/wdata/strb in cycle 0; no rvalid in cycle 1.
REQ-036 Contention, fixed priority: both requesting for 3 cycles -> ls_gnt=1 and if_gnt=0 in all 3 cycles; three ls_rvalid pulses, each one cycle after its grant.
REQ-037 Contention with MEM_ARBITER_RR_EN: both requesting for 4 cycles from reset -> grants if, ls, if, ls.
REQ-038 Reset mid-read: fetch granted, reset asserted before the next edge -> if_rvalid stays 0 after release; state IDLE.
REQ-039 Pipelined loads: ls reads to 0x0, 0x4, 0x8 on consecutive cycles -> ls_rvalid high for 3 consecutive cycles, rdata in order.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter (instruction fetch and load/store) in front of a
//   single memory port with one-cycle read latency. The grant is
//   combinational. A registered owner tag records whose read is in flight,
//   so that the memory read data the following cycle goes to that requester.
//
//   Optional feature macro: MEM_ARBITER_RR_EN
//     undefined : fixed priority; on contention ls wins and if stalls
//     defined   : 1-bit round-robin pointer picks the winner on contention
//
// Parameters
//   ADDR_W : byte address width
//   DATA_W : data width (strobe width DATA_W/8)
//
// Ports
//   clk, reset                  : clock (rising edge), async active-high reset
//   if_req_i, if_addr_i         : fetch read request
//   if_gnt_o                    : fetch accepted this cycle
//   if_rvalid_o, if_rdata_o     : fetch read response
//   ls_req_i, ls_addr_i,
//   ls_we_i, ls_wdata_i,
//   ls_strb_i                   : load/store request
//   ls_gnt_o                    : load/store accepted this cycle
//   ls_rvalid_o, ls_rdata_o     : load read response
//   mem_addr_o, mem_wdata_o,
//   mem_strb_o, mem_we_o        : shared memory request
//   mem_rdata_i                 : memory read data, one cycle after request
//
// Owner FSM
//   state | meaning
//   IDLE  | no read response due this cycle
//   RD_IF | memory read data this cycle belongs to fetch
//   RD_LS | memory read data this cycle belongs to load/store

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,

  input  logic                ls_req_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic                ls_we_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_strb_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,

  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_strb_o,
  output logic                mem_we_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_LS = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   if_rvalid_q, if_rvalid_d;
  logic   ls_rvalid_q, ls_rvalid_d;
  logic   ls_wins;
  logic   if_gnt, ls_gnt;

`ifdef MEM_ARBITER_RR_EN
  // rr_q = 0 favours fetch, 1 favours load/store
  logic   rr_q, rr_d;
  assign ls_wins = rr_q;
`else
  assign ls_wins = 1'b1;
`endif

  // Grants are masked by reset so nothing is sampled while it is asserted.
  always_comb begin
    if_gnt = ~reset & if_req_i & (~ls_req_i | ~ls_wins);
    ls_gnt = ~reset & ls_req_i & (~if_req_i | ls_wins);
  end

  always_comb begin
    owner_d = IDLE;
    if (ls_gnt) begin
      owner_d = ls_we_i ? IDLE : RD_LS;
    end else if (if_gnt) begin
      owner_d = RD_IF;
    end
    if_rvalid_d = (owner_d == RD_IF);
    ls_rvalid_d = (owner_d == RD_LS);
  end

`ifdef MEM_ARBITER_RR_EN
  // Only a contended grant moves the pointer; it then favours the loser.
  always_comb begin
    rr_d = rr_q;
    if (if_gnt && ls_req_i) begin
      rr_d = 1'b1;
    end else if (ls_gnt && if_req_i) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= IDLE;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign ls_gnt_o    = ls_gnt;

  assign mem_addr_o  = ls_gnt ? ls_addr_i : (if_gnt ? if_addr_i : '0);
  assign mem_we_o    = ls_gnt & ls_we_i;
  assign mem_wdata_o = ls_gnt ? ls_wdata_i : '0;
  assign mem_strb_o  = ls_gnt ? ls_strb_i : '0;

  // Read data is steered only to the owner of the in-flight read.
  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rvalid_q ? mem_rdata_i : '0;
  assign ls_rdata_o  = ls_rvalid_q ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o, if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              ls_req_i, ls_we_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic [3:0]        ls_strb_i;
  logic              ls_gnt_o, ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [3:0]        mem_strb_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_rdata_i;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_addr_i(ls_addr_i), .ls_we_i(ls_we_i),
    .ls_wdata_i(ls_wdata_i), .ls_strb_i(ls_strb_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_strb_o(mem_strb_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i)
  );

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: a queue of reads awaiting their response cycle.
  typedef struct { int due; bit is_ls; } rsp_t;
  rsp_t rq[$];
  int   cyc = 0;
  bit   rr_m = 1'b0;       // 1 means load/store is favoured on contention
  bit   e_if_last, e_ls_last;

  logic              obs_if_gnt, obs_ls_gnt, obs_we, obs_ifv, obs_lsv;
  logic [ADDR_W-1:0] obs_addr;
  logic [DATA_W-1:0] obs_wdata, obs_ifd, obs_lsd;
  logic [3:0]        obs_strb;

  // Inputs are set at posedge+1; outputs checked mid-cycle.
  task automatic tick(input bit late_rst);
    bit e_if, e_ls, e_ifv, e_lsv;
    logic [ADDR_W-1:0] e_addr;
    #4;
    e_ifv = 0; e_lsv = 0;
    if (reset) begin
      e_if = 0; e_ls = 0;
      rq.delete();
      rr_m = 0;
    end else if (if_req_i && ls_req_i) begin
`ifdef MEM_ARBITER_RR_EN
      e_ls = rr_m;
`else
      e_ls = 1;
`endif
      e_if = !e_ls;
      rr_m = e_if;   // loser gets the next contended grant
    end else begin
      e_if = if_req_i;
      e_ls = ls_req_i;
    end
    if (!reset && rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].is_ls) e_lsv = 1; else e_ifv = 1;
      void'(rq.pop_front());
    end
    e_addr = e_ls ? ls_addr_i : (e_if ? if_addr_i : '0);

    chk("if_gnt", if_gnt_o, e_if);
    chk("ls_gnt", ls_gnt_o, e_ls);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_we", mem_we_o, e_ls & ls_we_i);
    chk("mem_wdata", mem_wdata_o, e_ls ? ls_wdata_i : '0);
    chk("mem_strb", mem_strb_o, e_ls ? ls_strb_i : 4'h0);
    chk("if_rvalid", if_rvalid_o, e_ifv);
    chk("if_rdata", if_rdata_o, e_ifv ? mem_rdata_i : '0);
    chk("ls_rvalid", ls_rvalid_o, e_lsv);
    chk("ls_rdata", ls_rdata_o, e_lsv ? mem_rdata_i : '0);

    if (e_if) rq.push_back('{due: cyc + 1, is_ls: 1'b0});
    if (e_ls && !ls_we_i) rq.push_back('{due: cyc + 1, is_ls: 1'b1});
    e_if_last = e_if; e_ls_last = e_ls;

    obs_if_gnt = if_gnt_o; obs_ls_gnt = ls_gnt_o; obs_we = mem_we_o;
    obs_addr = mem_addr_o; obs_wdata = mem_wdata_o; obs_strb = mem_strb_o;
    obs_ifv = if_rvalid_o; obs_ifd = if_rdata_o;
    obs_lsv = ls_rvalid_o; obs_lsd = ls_rdata_o;

    if (late_rst) begin
      #3 reset = 1'b1;
      rq.delete();
      rr_m = 0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_addr_i = '0;
    ls_req_i = 0; ls_addr_i = '0; ls_we_i = 0; ls_wdata_i = '0; ls_strb_i = '0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs(); mem_rdata_i = $urandom;
    tick(0);
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    mem_rdata_i = '0;
    @(posedge clk); #1;

    // reset state: everything quiet while reset is high
    if_req_i = 1; ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h44; if_addr_i = 32'h48;
    tick(0);
    chk("rst_if_gnt", obs_if_gnt, 0);
    chk("rst_ls_gnt", obs_ls_gnt, 0);
    chk("rst_we", obs_we, 0);
    chk("rst_addr", obs_addr, 0);
    reset = 0; idle_inputs();
    tick(0);

    // fetch only
    if_req_i = 1; if_addr_i = 32'h10;
    tick(0);
    chk("f_gnt", obs_if_gnt, 1);
    chk("f_addr", obs_addr, 32'h10);
    if_req_i = 0; mem_rdata_i = 32'hDEADBEEF;
    tick(0);
    chk("f_rvalid", obs_ifv, 1);
    chk("f_rdata", obs_ifd, 32'hDEADBEEF);
    chk("f_ls_rvalid", obs_lsv, 0);

    // store
    ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h20; ls_wdata_i = 32'h12345678; ls_strb_i = 4'hF;
    tick(0);
    chk("st_we", obs_we, 1);
    chk("st_addr", obs_addr, 32'h20);
    chk("st_wdata", obs_wdata, 32'h12345678);
    chk("st_strb", obs_strb, 4'hF);
    idle_inputs(); mem_rdata_i = 32'hCAFE0001;
    tick(0);
    chk("st_no_lsv", obs_lsv, 0);
    chk("st_no_ifv", obs_ifv, 0);

`ifndef MEM_ARBITER_RR_EN
    // contention, fixed priority: ls wins three times
    if_req_i = 1; if_addr_i = 32'h100; ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h200;
    for (int i = 0; i < 3; i++) begin
      mem_rdata_i = 32'hA000_0000 + i;
      tick(0);
      chk("fp_ls_gnt", obs_ls_gnt, 1);
      chk("fp_if_gnt", obs_if_gnt, 0);
      if (i > 0) chk("fp_lsv", obs_lsv, 1);
    end
    ls_req_i = 0; mem_rdata_i = 32'hA000_0003;
    tick(0);
    chk("fp_lsv3", obs_lsv, 1);
    chk("fp_lsd3", obs_lsd, 32'hA000_0003);
    chk("fp_if_late_gnt", obs_if_gnt, 1);
    idle_inputs();
    tick(0);
`else
    // contention with round robin from reset: if, ls, if, ls
    do_reset();
    if_req_i = 1; if_addr_i = 32'h100; ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h200;
    for (int i = 0; i < 4; i++) begin
      mem_rdata_i = $urandom;
      tick(0);
      chk("rr_if_gnt", obs_if_gnt, (i % 2) == 0);
      chk("rr_ls_gnt", obs_ls_gnt, (i % 2) == 1);
    end
    idle_inputs();
    tick(0);
`endif

    // reset between a fetch grant and its response
    if_req_i = 1; if_addr_i = 32'h30;
    tick(1);
    chk("rm_gnt", obs_if_gnt, 1);
    if_req_i = 0; mem_rdata_i = 32'h5555AAAA;
    tick(0);
    chk("rm_ifv_in_rst", obs_ifv, 0);
    reset = 0;
    tick(0);
    chk("rm_ifv_after", obs_ifv, 0);

    // pipelined loads
    ls_req_i = 1; ls_we_i = 0; ls_strb_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      ls_addr_i = 32'(i * 4);
      if (i == 3) ls_req_i = 0;
      mem_rdata_i = 32'hB000_0000 + 32'(i);
      tick(0);
      if (i > 0) begin
        chk("pl_lsv", obs_lsv, 1);
        chk("pl_lsd", obs_lsd, 32'hB000_0000 + 32'(i));
      end
    end
    tick(0);
    chk("pl_lsv_end", obs_lsv, 0);

    // randomized traffic obeying the hold-until-granted rule
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (!if_req_i || e_if_last) begin
        if_req_i = ($urandom_range(0, 3) != 0);
        if_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_req_i || e_ls_last) begin
        ls_req_i = ($urandom_range(0, 2) != 0);
        ls_we_i = $urandom_range(0, 1);
        ls_addr_i = $urandom & 32'hFFFF_FFFC;
        ls_wdata_i = $urandom;
        ls_strb_i = 4'($urandom);
      end
      mem_rdata_i = $urandom;
      if (reset) reset = 0;
      else if ($urandom_range(0, 60) == 0) reset = 1;
      tick($urandom_range(0, 80) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
